// File: rtl/apb_stream_fifo_pkg.sv
// apb_stream_fifo_pkg
// Shared constants for the APB-to-stream FIFO slave: register addresses
// and bit positions inside the STATUS and CTRL registers.
package apb_stream_fifo_pkg;

    // Register map (PADDR values)
    localparam int ADDR_DATA   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_CTRL   = 2;

    // STATUS bit positions; bits [STAT_CNT_W-1:0] carry the fill count
    localparam int STAT_OVF    = 7;
    localparam int STAT_FULL   = 5;
    localparam int STAT_EMPTY  = 4;
    localparam int STAT_CNT_W  = 4;

    // CTRL bit positions; flush and clear-ovf are one-shot, enable is held
    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_EN      = 7;

endpackage

// File: rtl/apb_stream_fifo_if.sv
// apb_stream_fifo_if
// Bundles the APB slave bus and the byte stream output of apb_stream_fifo.
//   APB   : PSEL, PADDR, PENABLE, PWRITE, PWDATA (to slave), PRDATA, PREADY (from slave)
//   Stream: m_valid, m_data (from slave), m_ready (to slave)
// Handshake: a stream byte transfers on a rising PCLK edge where m_valid and
// m_ready are both 1; m_valid does not depend on m_ready. An APB transfer
// commits on the edge where PSEL and PENABLE are both 1 (PREADY is always 1).
interface apb_stream_fifo_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              PSEL;
    logic [ADDR_W-1:0] PADDR;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, m_ready,
        output PRDATA, PREADY, m_valid, m_data
    );

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA, m_ready,
        input  PRDATA, PREADY, m_valid, m_data
    );
endinterface

// File: rtl/apb_stream_fifo_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with power-of-two depth.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   push_i, wdata_i      : write request and data (ignored when full)
//   pop_i                : read request (ignored when empty)
//   flush_i              : empties the FIFO, discarding same-edge push/pop
//   head_o               : oldest entry, 0 when empty
//   count_o, full_o, empty_o : occupancy from the registered count
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // Fullness is judged on the registered count, so a push into a full
    // FIFO is refused even if a pop frees a slot on the same edge.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are PTR_W wide, so they wrap modulo DEPTH on their own
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked to 0 while empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_stream_fifo.sv
// apb_stream_fifo
// APB slave that buffers bytes written to its DATA register and drains them
// through a valid/ready stream port. STATUS reports fill level and a sticky
// overflow flag; CTRL provides flush, overflow clear and stream enable.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   bus (slave)   : APB PSEL/PADDR/PENABLE/PWRITE/PWDATA/PRDATA/PREADY and
//                   stream m_valid/m_data/m_ready
module apb_stream_fifo
    import apb_stream_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_stream_fifo_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              access;
    logic              wr_data, wr_ctrl;
    logic              sel_data, sel_status, sel_ctrl;
    logic              ovf_q, ovf_d;
    logic              en_q, en_d;
    logic              flush, pop, m_valid_w;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic [DATA_W-1:0] status_v, ctrl_v, rdata;

    // Only the access phase has side effects; the setup phase is inert
    assign access     = bus.PSEL & bus.PENABLE;
    assign sel_data   = (bus.PADDR == ADDR_W'(ADDR_DATA));
    assign sel_status = (bus.PADDR == ADDR_W'(ADDR_STATUS));
    assign sel_ctrl   = (bus.PADDR == ADDR_W'(ADDR_CTRL));
    assign wr_data    = access & bus.PWRITE & sel_data;
    assign wr_ctrl    = access & bus.PWRITE & sel_ctrl;
    assign flush      = wr_ctrl & bus.PWDATA[CTRL_FLUSH];

    assign m_valid_w  = en_q & ~empty;
    assign pop        = m_valid_w & bus.m_ready;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .push_i  (wr_data),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (bus.PWDATA),
        .head_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        ovf_d = ovf_q;
        en_d  = en_q;
        if (wr_ctrl) begin
            en_d = bus.PWDATA[CTRL_EN];
            if (bus.PWDATA[CTRL_CLR_OVF]) ovf_d = 1'b0;
        end
        // Set after clear so an overflow on the clearing edge is not lost
        if (wr_data && full) ovf_d = 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ovf_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            en_q  <= en_d;
        end
    end

    always_comb begin
        status_v                   = '0;
        status_v[STAT_OVF]         = ovf_q;
        status_v[STAT_FULL]        = full;
        status_v[STAT_EMPTY]       = empty;
        status_v[STAT_CNT_W-1:0]   = STAT_CNT_W'(count);
        ctrl_v                     = '0;
        ctrl_v[CTRL_EN]            = en_q;
    end

    // Read data is combinational from registered state, so a read returns
    // the values that held before the current edge's updates.
    always_comb begin
        rdata = '0;
        if (access && !bus.PWRITE) begin
            if (sel_data)        rdata = head;
            else if (sel_status) rdata = status_v;
            else if (sel_ctrl)   rdata = ctrl_v;
        end
    end

    assign bus.PRDATA  = rdata;
    assign bus.PREADY  = 1'b1;
    assign bus.m_valid = m_valid_w;
    assign bus.m_data  = head;

endmodule
